// File: rtl/signed_field_packer_if.sv
// Request/result/error-tracking signal bundle for signed_field_packer.
// The master drives requests and consumes results; the packer is the slave.
interface signed_field_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_value;
  logic [1:0]  in_sel;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_field;
  logic [3:0]  out_width;
  logic        out_fit;
  logic        err_clear;
  logic        err_sticky;
  logic [7:0]  err_count;

  modport master (
    output in_valid, in_value, in_sel, out_ready, err_clear,
    input  in_ready, out_valid, out_field, out_width, out_fit, err_sticky, err_count
  );

  modport slave (
    input  in_valid, in_value, in_sel, out_ready, err_clear,
    output in_ready, out_valid, out_field, out_width, out_fit, err_sticky, err_count
  );
endinterface

// File: rtl/signed_field_packer.sv
// Packs a 16-bit two's-complement value into a 5/6/9/11-bit signed field,
// flags whether it fits, and buffers results in a 2-entry in-order FIFO.
// Non-fitting accepts are tracked by a sticky flag and a saturating counter.
module signed_field_packer (
  input  logic                  clk,
  input  logic                  rst,
  signed_field_packer_if.slave  bus
);

  // FIFO state: head is the entry presented on out_*, tail is the second slot.
  logic [1:0]  r_occ;
  logic [10:0] r_head_field;
  logic [3:0]  r_head_width;
  logic        r_head_fit;
  logic [10:0] r_tail_field;
  logic [3:0]  r_tail_width;
  logic        r_tail_fit;

  logic [7:0]  r_err_count;
  logic        r_err_sticky;

  logic [1:0]  w_occ_nxt;
  logic [10:0] w_head_field_nxt;
  logic [3:0]  w_head_width_nxt;
  logic        w_head_fit_nxt;
  logic [10:0] w_tail_field_nxt;
  logic [3:0]  w_tail_width_nxt;
  logic        w_tail_fit_nxt;
  logic [7:0]  w_err_count_nxt;
  logic        w_err_sticky_nxt;

  logic [10:0] w_field;
  logic [3:0]  w_width;
  logic        w_fit;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;
  logic        w_drain;
  logic        w_nonfit_accept;

  // Handshake qualifiers derive from registered occupancy only.
  assign w_in_ready      = (r_occ != 2'd2);
  assign w_out_valid     = (r_occ != 2'd0);
  assign w_accept        = bus.in_valid & w_in_ready;
  assign w_drain         = w_out_valid & bus.out_ready;
  assign w_nonfit_accept = w_accept & ~w_fit;

  // Field extraction and fit test: the bits from N-1 upward must be a pure sign extension.
  always_comb begin
    w_field = '0;
    w_width = 4'd5;
    w_fit   = 1'b0;
    case (bus.in_sel)
      2'b00: begin
        w_field = {6'b0, bus.in_value[4:0]};
        w_width = 4'd5;
        w_fit   = (&bus.in_value[15:4]) | ~(|bus.in_value[15:4]);
      end
      2'b01: begin
        w_field = {5'b0, bus.in_value[5:0]};
        w_width = 4'd6;
        w_fit   = (&bus.in_value[15:5]) | ~(|bus.in_value[15:5]);
      end
      2'b10: begin
        w_field = {2'b0, bus.in_value[8:0]};
        w_width = 4'd9;
        w_fit   = (&bus.in_value[15:8]) | ~(|bus.in_value[15:8]);
      end
      default: begin
        w_field = bus.in_value[10:0];
        w_width = 4'd11;
        w_fit   = (&bus.in_value[15:10]) | ~(|bus.in_value[15:10]);
      end
    endcase
  end

  // FIFO next state: push fills the first free slot, pop promotes tail to head.
  always_comb begin
    w_occ_nxt        = r_occ;
    w_head_field_nxt = r_head_field;
    w_head_width_nxt = r_head_width;
    w_head_fit_nxt   = r_head_fit;
    w_tail_field_nxt = r_tail_field;
    w_tail_width_nxt = r_tail_width;
    w_tail_fit_nxt   = r_tail_fit;
    case ({w_accept, w_drain})
      2'b10: begin
        if (r_occ == 2'd0) begin
          w_head_field_nxt = w_field;
          w_head_width_nxt = w_width;
          w_head_fit_nxt   = w_fit;
        end else begin
          w_tail_field_nxt = w_field;
          w_tail_width_nxt = w_width;
          w_tail_fit_nxt   = w_fit;
        end
        w_occ_nxt = r_occ + 2'd1;
      end
      2'b01: begin
        w_head_field_nxt = r_tail_field;
        w_head_width_nxt = r_tail_width;
        w_head_fit_nxt   = r_tail_fit;
        w_occ_nxt        = r_occ - 2'd1;
      end
      2'b11: begin
        // Only reachable at occupancy 1: the new entry replaces the departing head.
        w_head_field_nxt = w_field;
        w_head_width_nxt = w_width;
        w_head_fit_nxt   = w_fit;
      end
      default: ;
    endcase
  end

  // Error tracking: a coincident non-fit accept wins over err_clear and restarts at 1.
  always_comb begin
    w_err_count_nxt  = r_err_count;
    w_err_sticky_nxt = r_err_sticky;
    if (w_nonfit_accept) begin
      w_err_sticky_nxt = 1'b1;
      if (bus.err_clear) begin
        w_err_count_nxt = 8'd1;
      end else if (r_err_count != 8'hFF) begin
        w_err_count_nxt = r_err_count + 8'd1;
      end
    end else if (bus.err_clear) begin
      w_err_count_nxt  = 8'd0;
      w_err_sticky_nxt = 1'b0;
    end
  end

  // State registers with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ        <= 2'd0;
      r_head_field <= '0;
      r_head_width <= '0;
      r_head_fit   <= 1'b0;
      r_tail_field <= '0;
      r_tail_width <= '0;
      r_tail_fit   <= 1'b0;
      r_err_count  <= 8'd0;
      r_err_sticky <= 1'b0;
    end else begin
      r_occ        <= w_occ_nxt;
      r_head_field <= w_head_field_nxt;
      r_head_width <= w_head_width_nxt;
      r_head_fit   <= w_head_fit_nxt;
      r_tail_field <= w_tail_field_nxt;
      r_tail_width <= w_tail_width_nxt;
      r_tail_fit   <= w_tail_fit_nxt;
      r_err_count  <= w_err_count_nxt;
      r_err_sticky <= w_err_sticky_nxt;
    end
  end

  // Result outputs read zero whenever nothing is buffered.
  always_comb begin
    bus.in_ready   = w_in_ready;
    bus.out_valid  = w_out_valid;
    bus.out_field  = w_out_valid ? r_head_field : '0;
    bus.out_width  = w_out_valid ? r_head_width : '0;
    bus.out_fit    = w_out_valid & r_head_fit;
    bus.err_count  = r_err_count;
    bus.err_sticky = r_err_sticky;
  end

endmodule

// File: doc/signed_field_packer.md
SIGNED_FIELD_PACKER -- requirements
Module: signed_field_packer

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL: in_valid  input  1  request valid.
REQ-004 SHALL: in_ready  output  1  block can accept a request this cycle.
REQ-005 SHALL: in_value  input  16  two's-complement value to pack.
REQ-006 SHALL: in_sel  input  2  target field: 00=imm5 (N=5), 01=offset6 (N=6), 10=PCoffset9 (N=9), 11=PCoffset11 (N=11).
REQ-007 SHALL: out_valid  output  1  head result valid.
REQ-008 SHALL: out_ready  input  1  consumer takes head result.
REQ-009 SHALL: out_field  output  11  packed field in_value[N-1:0], right-justified, bits [10:N] zero.
REQ-010 SHALL: out_width  output  4  N of the head result (5, 6, 9 or 11).
REQ-011 SHALL: out_fit  output  1  1 = in_value representable in N-bit signed field.
REQ-012 SHALL: err_clear  input  1  single-cycle clear of error tracking.
REQ-013 SHALL: err_sticky  output  1  set on any accepted non-fitting request.
REQ-014 SHALL: err_count  output  8  count of accepted non-fitting requests, saturating.

Function
REQ-015 SHALL: accept occurs on a cycle with in_valid=1 and in_ready=1; drain occurs on a cycle with out_valid=1 and out_ready=1.
REQ-016 SHALL: results buffered in a 2-entry in-order FIFO of {out_field, out_width, out_fit}; in_ready = (occupancy != 2), from registered state only.
REQ-017 SHALL: fit computed as in_value[15:N-1] all-ones or all-zeros, i.e. -2^(N-1) <= value <= 2^(N-1)-1.
REQ-018 SHALL: non-fitting values still produce a result: out_field = in_value[N-1:0], out_fit=0.
REQ-019 SHALL: latency 1 cycle: request accepted at edge t is visible on out_* with out_valid=1 after edge t when FIFO was empty or draining its last entry.
REQ-020 SHALL: out_field/out_width/out_fit held stable while out_valid=1 and out_ready=0.
REQ-021 SHALL: simultaneous accept and drain at occupancy 1 keep occupancy 1, new entry becomes head next cycle; at occupancy 2 only drain possible.
REQ-022 SHALL: out_ready with out_valid=0 and in_valid with in_ready=0 ignored, no state change.
REQ-023 SHALL: err_count increments by 1 per accepted non-fit, saturating at 255; err_sticky set on same edge.
REQ-024 SHALL: err_clear zeroes err_count and err_sticky; if a non-fit accept coincides, result is err_count=1, err_sticky=1.
REQ-025 SHALL: out_field, out_width, out_fit read 0 when out_valid=0.

Reset
REQ-026 SHALL: rst=1 at edge: occupancy 0, out_valid=0, in_ready=1, out_field=0, out_width=0, out_fit=0, err_count=0, err_sticky=0.
REQ-027 SHALL: rst has priority over every other input, including mid-operation with buffered entries (entries discarded) and coincident accept/err_clear.

Verification
REQ-028 SHALL: sel=01, value 0x001F -> next cycle out_valid=1, out_field=0x01F, out_width=6, out_fit=1; sel=01, value 0xFFE0 -> out_field=0x020, out_fit=1.
REQ-029 SHALL: sel=01, value 0x0020 -> out_field=0x020, out_fit=0, err_count=1, err_sticky=1; sel=11, value 0xFC00 -> out_field=0x400, fit=1; sel=11, value 0x0400 -> fit=0; sel=00, value 0xFFF0 -> out_field=0x010, width=5, fit=1.
REQ-030 SHALL: out_ready=0, push A,B,C back-to-back -> A,B accepted, in_ready=0 from cycle after B, C held; out_ready=1 -> A then B then C, one per cycle, values stable while stalled.
REQ-031 SHALL: continuous in_valid and out_ready=1 -> one result per cycle, occupancy steady at 1, no drops.
REQ-032 SHALL: 260 non-fit accepts -> err_count=255; err_clear together with non-fit accept -> err_count=1, err_sticky=1.
REQ-033 SHALL: rst asserted with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1, err_count=0, err_sticky=0.
